// File: rtl/synth_pkg.sv
// Types and constants shared by the octave-down FSM and the tone divider.
package synth_pkg;

  typedef logic [1:0] octave_t;

  localparam int unsigned OCT_MAX_SHIFT = 3;

  typedef enum logic {TD_IDLE, TD_RUN} tone_state_t;

endpackage

// File: rtl/octave_tone_divider.sv
// Square-wave tone generator: half-period = note_div << oct_switch clk cycles,
// with pitch/octave latched only at half-period boundaries so changes are glitch-free.
module octave_tone_divider
  import synth_pkg::*;
#(
  parameter int unsigned CNT_W = 18
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             en,
  input  logic [CNT_W-1:0] note_div,
  input  octave_t          oct_switch,
  output logic             wave_out,
  output logic             edge_tick,
  output logic             active
);

  localparam int unsigned TGT_W = CNT_W + OCT_MAX_SHIFT;

  tone_state_t      state_q, state_d;
  logic [TGT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] shd_div_q, shd_div_d;
  octave_t          shd_oct_q, shd_oct_d;
  logic             wave_q, wave_d;
  logic             tick_q, tick_d;
  logic             active_q, active_d;
  logic [TGT_W-1:0] target;

  always_comb begin
    // Zero-extend before shifting so octave 3 (x8) never truncates.
    target    = {{OCT_MAX_SHIFT{1'b0}}, shd_div_q} << shd_oct_q;
    state_d   = state_q;
    cnt_d     = cnt_q;
    shd_div_d = shd_div_q;
    shd_oct_d = shd_oct_q;
    wave_d    = wave_q;
    tick_d    = 1'b0;
    case (state_q)
      TD_IDLE: begin
        wave_d = 1'b0;
        cnt_d  = '0;
        if (en && (note_div != '0)) begin
          state_d   = TD_RUN;
          shd_div_d = note_div;
          shd_oct_d = oct_switch;
        end
      end
      TD_RUN: begin
        if (!en) begin
          // Abort outranks any boundary event on the same edge.
          state_d = TD_IDLE;
          wave_d  = 1'b0;
          cnt_d   = '0;
        end else if (cnt_q == (target - TGT_W'(1))) begin
          cnt_d     = '0;
          tick_d    = 1'b1;
          shd_div_d = note_div;
          shd_oct_d = oct_switch;
          if (note_div == '0) begin
            state_d = TD_IDLE;
            wave_d  = 1'b0;
          end else begin
            wave_d = ~wave_q;
          end
        end else begin
          cnt_d = cnt_q + TGT_W'(1);
        end
      end
      default: state_d = TD_IDLE;
    endcase
    active_d = (state_d == TD_RUN);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= TD_IDLE;
      cnt_q     <= '0;
      shd_div_q <= '0;
      shd_oct_q <= '0;
      wave_q    <= 1'b0;
      tick_q    <= 1'b0;
      active_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shd_div_q <= shd_div_d;
      shd_oct_q <= shd_oct_d;
      wave_q    <= wave_d;
      tick_q    <= tick_d;
      active_q  <= active_d;
    end
  end

  assign wave_out  = wave_q;
  assign edge_tick = tick_q;
  assign active    = active_q;

endmodule

// File: tb/tb_octave_tone_divider.sv
// Bench for octave_tone_divider: per-cycle scoreboard fed by a countdown reference
// model, plus directed half-period interval measurements.
module tb_octave_tone_divider;
  import synth_pkg::*;

  localparam int unsigned CNT_W = 10;

  logic             clk = 1'b0;
  logic             nrst;
  logic             en;
  logic [CNT_W-1:0] note_div;
  octave_t          oct_switch;
  logic             wave_out;
  logic             edge_tick;
  logic             active;

  int checks   = 0;
  int failures = 0;
  int n;

  typedef struct packed {
    logic wave;
    logic tick;
    logic act;
  } exp_t;

  exp_t exp_q[$];

  octave_tone_divider #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .nrst       (nrst),
    .en         (en),
    .note_div   (note_div),
    .oct_switch (oct_switch),
    .wave_out   (wave_out),
    .edge_tick  (edge_tick),
    .active     (active)
  );

  always #5 clk = ~clk;

  function automatic int half_period(input int nd, input int od);
    return nd * (1 << od);
  endfunction

  // Reference model: remaining cycles of the current half-period, counted down.
  bit m_run, m_wave, m_tick;
  int m_rem;

  initial begin
    m_run = 0; m_wave = 0; m_tick = 0; m_rem = 0;
    forever begin
      @(posedge clk);
      if (!nrst) begin
        m_run = 0; m_wave = 0; m_tick = 0; m_rem = 0;
      end else if (!m_run) begin
        m_tick = 0;
        m_wave = 0;
        if (en && note_div != 0) begin
          m_run = 1;
          m_rem = half_period(int'(note_div), int'(oct_switch));
        end
      end else if (!en) begin
        m_run = 0; m_wave = 0; m_tick = 0;
      end else begin
        m_rem = m_rem - 1;
        m_tick = (m_rem == 0);
        if (m_rem == 0) begin
          if (note_div == 0) begin
            m_run = 0;
            m_wave = 0;
          end else begin
            m_wave = !m_wave;
            m_rem = half_period(int'(note_div), int'(oct_switch));
          end
        end
      end
      exp_q.push_back(exp_t'{wave: m_wave, tick: m_tick, act: m_run});
    end
  end

  // Monitor: one expected triple per clock, compared mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL scoreboard_empty t=%0t", $time);
      end else begin
        e = exp_q.pop_front();
        if (wave_out !== e.wave || edge_tick !== e.tick || active !== e.act) begin
          failures++;
          $display("FAIL cycle t=%0t got wave=%b tick=%b active=%b required wave=%b tick=%b active=%b",
                   $time, wave_out, edge_tick, active, e.wave, e.tick, e.act);
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s t=%0t got %0d required %0d", name, $time, act, req);
    end
  endtask

  // Counts negedges until edge_tick is seen; optionally changes inputs at negedge change_at.
  task automatic gap(input int change_at, input logic [CNT_W-1:0] new_div,
                     input octave_t new_oct, output int cnt);
    for (int i = 1; i <= 20000; i++) begin
      @(negedge clk);
      if (i == change_at) begin
        note_div   = new_div;
        oct_switch = new_oct;
      end
      if (edge_tick === 1'b1) begin
        cnt = i;
        return;
      end
    end
    cnt = -1;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int seg_len;
    int r;
    nrst = 1'b0; en = 1'b1; note_div = 5; oct_switch = 0;
    #1;
    check("reset_wave", int'(wave_out), 0);
    check("reset_active", int'(active), 0);
    check("reset_tick", int'(edge_tick), 0);
    repeat (3) @(negedge clk);

    // Base octave, note_div=4
    note_div = 4; oct_switch = 0; nrst = 1'b1;
    gap(0, 4, 0, n);
    check("first_rise_gap", n, 5);
    check("first_rise_wave", int'(wave_out), 1);
    gap(0, 4, 0, n);
    check("half_oct0", n, 4);
    check("wave_after_fall", int'(wave_out), 0);

    // Octave scaling 1..3
    for (int o = 1; o <= 3; o++) begin
      gap(1, 4, octave_t'(o), n);
      check("half_prev_oct", n, 4 << (o - 1));
      gap(0, 4, octave_t'(o), n);
      check("half_new_oct", n, 4 << o);
    end

    // Glitch-free octave change mid half-period
    @(negedge clk); en = 1'b0;
    @(negedge clk); en = 1'b1; note_div = 10; oct_switch = 0;
    gap(0, 10, 0, n);
    check("entry_note10", n, 11);
    gap(3, 10, 2, n);
    check("half_unchanged", n, 10);
    gap(0, 10, 2, n);
    check("half_oct2", n, 40);

    // Rest at boundary
    gap(2, 0, 2, n);
    check("rest_gap", n, 40);
    check("rest_active", int'(active), 0);
    check("rest_wave", int'(wave_out), 0);

    // Abort by en and restart
    @(negedge clk); note_div = 6; oct_switch = 0;
    gap(0, 6, 0, n);
    check("entry_note6", n, 7);
    repeat (2) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    check("abort_active", int'(active), 0);
    check("abort_wave", int'(wave_out), 0);
    en = 1'b1;
    gap(0, 6, 0, n);
    check("restart_gap", n, 7);
    check("restart_wave", int'(wave_out), 1);

    // Async reset mid-RUN with wave high
    @(negedge clk); #1 nrst = 1'b0;
    #1;
    check("async_rst_wave", int'(wave_out), 0);
    check("async_rst_active", int'(active), 0);
    @(negedge clk); nrst = 1'b1;
    @(negedge clk);
    check("rerun_active", int'(active), 1);
    gap(0, 6, 0, n);
    check("rerun_gap", n, 6);

    // Largest half-period: (2^CNT_W-1) x 8
    @(negedge clk); en = 1'b0;
    @(negedge clk); en = 1'b1; note_div = '1; oct_switch = 3;
    gap(0, '1, 3, n);
    check("max_entry_gap", n, 1023 * 8 + 1);
    gap(0, '1, 3, n);
    check("max_half", n, 1023 * 8);

    // Smallest: toggles every cycle
    @(negedge clk); en = 1'b0;
    @(negedge clk); en = 1'b1; note_div = 1; oct_switch = 0;
    gap(0, 1, 0, n);
    check("min_entry_gap", n, 2);
    gap(0, 1, 0, n);
    check("min_half_a", n, 1);
    gap(0, 1, 0, n);
    check("min_half_b", n, 1);

    // Randomized traffic against the scoreboard
    for (int seg = 0; seg < 120; seg++) begin
      @(negedge clk);
      nrst = 1'b1;
      en = 1'b1;
      note_div = CNT_W'($urandom_range(1, 12));
      oct_switch = octave_t'($urandom_range(0, 3));
      seg_len = $urandom_range(20, 150);
      for (int c = 0; c < seg_len; c++) begin
        @(negedge clk);
        nrst = 1'b1;
        r = $urandom_range(0, 999);
        if (r < 15)      note_div = CNT_W'($urandom_range(0, 12));
        else if (r < 40) oct_switch = octave_t'($urandom_range(0, 3));
        else if (r < 55) en = ~en;
        else if (r < 58) #1 nrst = 1'b0;
      end
    end

    @(negedge clk); nrst = 1'b1;
    repeat (3) @(negedge clk);
    @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
